// File: rtl/led_fader.sv
// Turns each edge of a slow blink level into a linear PWM brightness ramp:
// fade in on rise, fade out on fall, duty held between steps.
module led_fader #(
   parameter int PWM_BITS     = 8,
   parameter int STEP_PERIODS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                level,
   output logic                pwm_out,
   output logic [PWM_BITS:0]   duty,
   output logic                busy
);

   localparam logic [PWM_BITS:0] MAX = {1'b1, {PWM_BITS{1'b0}}};
   localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [SW-1:0] SLAST = SW'(STEP_PERIODS - 1);

   typedef enum logic [1:0] {
      S_OFF,
      S_UP,
      S_ON,
      S_DOWN
   } state_t;

   state_t              state_q, state_d;
   logic [PWM_BITS:0]   duty_q, duty_d;
   logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
   logic [SW-1:0]       scnt_q, scnt_d;
   logic                level_q, level_d;
   logic                pwm_q, pwm_d;
   logic                busy_q, busy_d;
   logic                rise, fall, bnd, step;

   always_comb begin
      rise    = level & ~level_q;
      fall    = ~level & level_q;
      bnd     = &pcnt_q;
      step    = bnd && (scnt_q == SLAST);
      level_d = level;
      pcnt_d  = pcnt_q + 1'b1;
      pwm_d   = ({1'b0, pcnt_q} < duty_q);

      // any edge restarts the step timer so a new ramp gets a full step
      scnt_d = scnt_q;
      if (rise || fall) begin
         scnt_d = '0;
      end else if (bnd) begin
         scnt_d = step ? '0 : scnt_q + 1'b1;
      end

      state_d = state_q;
      duty_d  = duty_q;
      unique case (state_q)
         S_OFF: begin
            duty_d = '0;
            if (rise) state_d = S_UP;
         end
         S_UP: begin
            if (fall) begin
               state_d = S_DOWN;
            end else if (duty_q == MAX) begin
               state_d = S_ON;
            end else if (step) begin
               duty_d = duty_q + 1'b1;
            end
         end
         S_ON: begin
            duty_d = MAX;
            if (fall) state_d = S_DOWN;
         end
         S_DOWN: begin
            if (rise) begin
               state_d = S_UP;
            end else if (duty_q == '0) begin
               state_d = S_OFF;
            end else if (step) begin
               duty_d = duty_q - 1'b1;
            end
         end
      endcase

      busy_d = (state_d == S_UP) || (state_d == S_DOWN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_OFF;
         duty_q  <= '0;
         pcnt_q  <= '0;
         scnt_q  <= '0;
         level_q <= 1'b0;
         pwm_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         pcnt_q  <= pcnt_d;
         scnt_q  <= scnt_d;
         level_q <= level_d;
         pwm_q   <= pwm_d;
         busy_q  <= busy_d;
      end
   end

   assign pwm_out = pwm_q;
   assign duty    = duty_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader at PWM_BITS=4, STEP_PERIODS=2: ramp model checked
// every cycle plus directed scenarios with literal expectations.
module tb_led_fader;

   localparam int PB  = 4;
   localparam int SP  = 2;
   localparam int MX  = 16;
   localparam int PER = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          level = 1'b0;
   logic          pwm_out;
   logic [PB:0]   duty;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   led_fader #(.PWM_BITS(PB), .STEP_PERIODS(SP)) dut (
      .clk     (clk),
      .rst     (rst),
      .level   (level),
      .pwm_out (pwm_out),
      .duty    (duty),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: ramp direction follows the last level edge; a step lands on
   // every SP-th period boundary counted since that edge.
   int m_k, m_nb, m_dir, m_duty, m_nd, m_pc;
   bit m_busy, m_pwm, m_prev, m_edge, m_bnd, m_nbusy;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_k = 0; m_nb = 0; m_dir = 0; m_duty = 0;
         m_busy = 0; m_pwm = 0; m_prev = 0;
      end else begin
         m_pc    = m_k % PER;
         m_bnd   = (m_pc == PER - 1);
         m_edge  = (level != m_prev);
         m_nd    = m_duty;
         m_nbusy = m_busy;
         if (m_edge) begin
            m_nb    = 0;
            m_dir   = level ? 1 : -1;
            m_nbusy = 1;
         end else begin
            if (m_bnd) m_nb++;
            if (m_busy) begin
               if ((m_dir > 0 && m_duty == MX) || (m_dir < 0 && m_duty == 0))
                  m_nbusy = 0;
               else if (m_bnd && (m_nb % SP == 0))
                  m_nd = m_duty + m_dir;
            end
         end
         m_pwm  = (m_pc < m_duty);
         m_duty = m_nd;
         m_busy = m_nbusy;
         m_prev = level;
         m_k++;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("model_duty", int'(duty), m_duty);
         chk("model_busy", int'(busy), int'(m_busy));
         chk("model_pwm", int'(pwm_out), int'(m_pwm));
      end
   end

   task automatic wait_duty(input string name, input int target, input int budget);
      bit hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (int'(duty) == target) hit = 1;
      end
      chk(name, int'(hit), 1);
   endtask

   int ones;
   int first;
   bit saw_pwm;

   initial begin
      #1;
      chk("rst_duty", int'(duty), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pwm", int'(pwm_out), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("off_idle_duty", int'(duty), 0);

      // fade in to full
      level = 1'b1;
      @(negedge clk);
      chk("rise_busy", int'(busy), 1);
      wait_duty("ramp_up_528", MX, 528);
      @(negedge clk);
      chk("on_busy_low", int'(busy), 0);
      ones = 0;
      repeat (PER) begin
         @(negedge clk);
         ones += int'(pwm_out);
      end
      chk("on_pwm_full", ones, PER);

      // fade out to zero
      level = 1'b0;
      @(negedge clk);
      chk("fall_busy", int'(busy), 1);
      chk("fall_no_jump", int'(duty), MX);
      wait_duty("ramp_dn_528", 0, 528);
      @(negedge clk);
      chk("off_busy_low", int'(busy), 0);
      ones = 0;
      repeat (PER) begin
         @(negedge clk);
         ones += int'(pwm_out);
      end
      chk("off_pwm_zero", ones, 0);

      // one-clock pulse: OFF->UP->DOWN->OFF
      saw_pwm = 0;
      level = 1'b1;
      @(negedge clk);
      level = 1'b0;
      saw_pwm |= pwm_out;
      chk("pulse_up_busy", int'(busy), 1);
      @(negedge clk);
      saw_pwm |= pwm_out;
      chk("pulse_dn_busy", int'(busy), 1);
      chk("pulse_duty", int'(duty), 0);
      @(negedge clk);
      saw_pwm |= pwm_out;
      chk("pulse_off_busy", int'(busy), 0);
      repeat (4) begin
         @(negedge clk);
         saw_pwm |= pwm_out;
      end
      chk("pulse_no_pwm", int'(saw_pwm), 0);

      // pulse width at duty 4: first 4 of 16 samples high
      level = 1'b1;
      wait_duty("reach_4", 4, 200);
      ones = 0;
      first = -1;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         ones += int'(pwm_out);
         if (pwm_out && first < 0) first = i;
      end
      chk("duty4_high", ones, 4);
      chk("duty4_align", first, 0);

      // reverse mid-ramp at duty 5
      wait_duty("reach_5", 5, 100);
      level = 1'b0;
      @(negedge clk);
      chk("rev_hold5", int'(duty), 5);
      for (int i = 0; i < 64 && int'(duty) == 5; i++) @(negedge clk);
      chk("rev_step4", int'(duty), 4);
      wait_duty("rev_step3", 3, 40);

      // turn back up, then async reset at duty 9
      level = 1'b1;
      @(negedge clk);
      chk("reup_kept", int'(duty), 3);
      wait_duty("reach_9", 9, 300);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_pwm", int'(pwm_out), 0);
      chk("arst_duty", int'(duty), 0);
      chk("arst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_busy", int'(busy), 1);
      chk("rel_duty", int'(duty), 0);
      wait_duty("rel_step1", 1, 40);
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
